store_path: RTL

Write-side counterpart of the core's writeback/load selection: accepts store requests from the execute stage, aligns data and generates byte enables, and routes each store by address to data memory, instruction memory or the memory-mapped I/O port. A 2-entry in-order store buffer decouples the pipeline from the memory targets. The I/O target uses a valid/ready handshake. The block flags loads that hit a pending buffered store so the core can stall them.

---
 rtl/store_path.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/store_path.sv
// store_path: aligns, routes and buffers core stores to dmem, imem or io,
// dropping misaligned and unmapped stores and flagging load/store overlap.
module store_path #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    output logic        st_stall,
    input  logic        bios_mode,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        sb_empty,
    output logic [3:0]  dmem_we,
    output logic [13:0] dmem_addr,
    output logic [31:0] dmem_din,
    output logic [3:0]  imem_we,
    output logic [13:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        io_valid,
    input  logic        io_ready,
    output logic [31:0] io_addr,
    output logic [31:0] io_data,
    output logic        err_misaligned
);

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_DMEM,
        TGT_IMEM,
        TGT_IO
    } tgt_e;

    typedef struct packed {
        tgt_e        tgt;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t     sb_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    tgt_e        tgt;
    logic [3:0]  we;
    logic [31:0] data;
    logic        misal;
    logic        fn_ok;
    logic        accept;
    logic        push;
    logic        drop_err;
    logic        pop;
    logic        has;
    logic        sel_d;
    logic        sel_i;
    logic        sel_io;
    logic        hit0;
    logic        hit1;
    entry_t      head;
    logic        unused_ld;

    assign unused_ld = ^ld_addr[1:0];

    assign st_stall = (count == 2'(DEPTH));
    assign sb_empty = (count == 2'd0);
    assign accept   = st_valid & ~st_stall;

    // 0011 overlaps both dmem and imem windows; dmem wins
    always_comb begin
        tgt = TGT_NONE;
        if (st_addr[31:30] == 2'b00 && st_addr[28])
            tgt = TGT_DMEM;
        else if (st_addr[31:29] == 3'b001 && bios_mode)
            tgt = TGT_IMEM;
        else if (st_addr[31:28] == 4'b1000)
            tgt = TGT_IO;
    end

    always_comb begin
        we    = 4'b0000;
        data  = st_data;
        misal = 1'b0;
        fn_ok = 1'b1;
        unique case (1'b1)
            (st_funct3 == 3'b000): begin
                we   = 4'b0001 << st_addr[1:0];
                data = {4{st_data[7:0]}};
            end
            (st_funct3 == 3'b001): begin
                we    = 4'b0011 << {st_addr[1], 1'b0};
                data  = {2{st_data[15:0]}};
                misal = st_addr[0];
            end
            (st_funct3 == 3'b010): begin
                we    = 4'b1111;
                misal = (st_addr[1:0] != 2'b00);
            end
            default: fn_ok = 1'b0;
        endcase
    end

    // unmapped stores are dropped silently, even if misaligned
    assign push     = accept & fn_ok & ~misal & (tgt != TGT_NONE);
    assign drop_err = accept & fn_ok &  misal & (tgt != TGT_NONE);

    assign has    = (count != 2'd0);
    assign head   = sb_q[rd_ptr];
    assign sel_d  = has && head.tgt == TGT_DMEM;
    assign sel_i  = has && head.tgt == TGT_IMEM;
    assign sel_io = has && head.tgt == TGT_IO;
    assign pop    = sel_d | sel_i | (sel_io & io_ready);

    assign dmem_we   = sel_d ? head.we : 4'b0000;
    assign dmem_addr = sel_d ? head.addr[15:2] : 14'd0;
    assign dmem_din  = sel_d ? head.data : 32'd0;
    assign imem_we   = sel_i ? head.we : 4'b0000;
    assign imem_addr = sel_i ? head.addr[15:2] : 14'd0;
    assign imem_din  = sel_i ? head.data : 32'd0;
    assign io_valid  = sel_io;
    assign io_addr   = sel_io ? head.addr : 32'd0;
    assign io_data   = sel_io ? head.data : 32'd0;

    assign hit0 = has &&
        sb_q[rd_ptr].addr[31:2] == ld_addr[31:2];
    assign hit1 = (count == 2'd2) &&
        sb_q[~rd_ptr].addr[31:2] == ld_addr[31:2];
    assign ld_hazard = hit0 | hit1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count          <= 2'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            err_misaligned <= 1'b0;
            sb_q[0]        <= '0;
            sb_q[1]        <= '0;
        end else begin
            err_misaligned <= drop_err;
            if (push) begin
                sb_q[wr_ptr] <= entry_t'{
                    tgt:  tgt,
                    we:   we,
                    addr: st_addr,
                    data: data
                };
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule
